// File: rtl/stdp_pkg.sv
// Shared types and arithmetic helpers for the STDP step scheduler.
// Helpers work on 64-bit signed values and saturate to a caller-given width.
package stdp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StSample,
    StUpdate
  } state_e;

  localparam int unsigned FRAC = 16;
  localparam logic signed [31:0] ONE = 32'sd1 <<< FRAC;

  typedef logic signed [63:0] wide_t;

  // Saturate v to the signed range of a w-bit value (w <= 62).
  function automatic wide_t sat(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
    return sat(a + b, w);
  endfunction

  function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int unsigned w);
    return sat(a - b, w);
  endfunction

  function automatic wide_t clamp(input wide_t v, input wide_t lo, input wide_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/stdp_step_scheduler_dw.sv
// Piecewise-linear STDP weight change: dw = b - sat(m * delta), gated by window.
// Requires N + Q + 1 <= 62 so the wide product is exact before saturation.
module stdp_dw
  import stdp_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned Q = 16
) (
  input  logic signed [N-1:0] m,
  input  logic signed [N-1:0] b,
  input  logic        [Q-1:0] delta,
  input  logic        [Q-1:0] window,
  output logic signed [N-1:0] dw,
  output logic                update_en
);

  wide_t prod;
  wide_t dw_w;

  always_comb begin
    // delta is unsigned, so the cast zero-extends while m sign-extends.
    prod      = sat(wide_t'(m) * wide_t'(delta), N);
    dw_w      = sat_sub(wide_t'(b), prod, N);
    dw        = dw_w[N-1:0];
    update_en = (delta < window) && (dw_w > 64'sd0);
  end

endmodule

// File: rtl/stdp_step_scheduler.sv
// Timestep sequencer for a pre/post neuron pair with STDP weight update.
// One step is APPLY, SETTLE x SETTLE_CYCLES, SAMPLE, UPDATE.
module stdp_step_scheduler
  import stdp_pkg::*;
#(
  parameter int unsigned N             = 32,
  parameter int unsigned Q             = 16,
  parameter int unsigned FRAC          = stdp_pkg::FRAC,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                enable_stdp,
  input  logic                is_spiking1,
  input  logic                is_spiking2,
  input  logic signed [N-1:0] weight_init,
  input  logic signed [N-1:0] w_min,
  input  logic signed [N-1:0] w_max,
  input  logic signed [N-1:0] m1,
  input  logic signed [N-1:0] b1,
  input  logic signed [N-1:0] m2,
  input  logic signed [N-1:0] b2,
  input  logic        [Q-1:0] window,
  output logic                apply,
  output logic                busy,
  output logic        [Q-1:0] step_count,
  output logic        [Q-1:0] last_pre_time,
  output logic        [Q-1:0] last_post_time,
  output logic                pre_valid,
  output logic                post_valid,
  output logic signed [N-1:0] weight,
  output logic                weight_valid
);

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e             state_q;
  logic [3:0]         settle_q;
  logic               apply_q, busy_q, weight_valid_q;
  logic [Q-1:0]       step_q, pre_time_q, post_time_q;
  logic               pre_valid_q, post_valid_q;
  logic signed [N-1:0] weight_q;
  logic               pot_cand_q, dep_cand_q;
  logic [Q-1:0]       pot_delta_q, dep_delta_q;

  logic signed [N-1:0] dw_pot, dw_dep;
  logic               pot_en, dep_en, pot_go, dep_go;
  wide_t              w_sum, w_next;
  logic signed [N-1:0] weight_next;

  stdp_dw #(.N(N), .Q(Q)) u_dw_pot (
    .m         (m1),
    .b         (b1),
    .delta     (pot_delta_q),
    .window    (window),
    .dw        (dw_pot),
    .update_en (pot_en)
  );

  stdp_dw #(.N(N), .Q(Q)) u_dw_dep (
    .m         (m2),
    .b         (b2),
    .delta     (dep_delta_q),
    .window    (window),
    .dw        (dw_dep),
    .update_en (dep_en)
  );

  // Candidates are mutually exclusive: each requires the other neuron silent.
  always_comb begin
    pot_go = pot_cand_q && pot_en && enable_stdp;
    dep_go = dep_cand_q && dep_en && enable_stdp;
    w_sum  = wide_t'(weight_q);
    if (pot_go) begin
      w_sum = sat_add(wide_t'(weight_q), wide_t'(dw_pot), N + 1);
    end else if (dep_go) begin
      w_sum = sat_sub(wide_t'(weight_q), wide_t'(dw_dep), N + 1);
    end
    w_next      = clamp(w_sum, wide_t'(w_min), wide_t'(w_max));
    weight_next = w_next[N-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      settle_q       <= '0;
      apply_q        <= 1'b0;
      busy_q         <= 1'b0;
      weight_valid_q <= 1'b0;
      step_q         <= '0;
      pre_time_q     <= '0;
      post_time_q    <= '0;
      pre_valid_q    <= 1'b0;
      post_valid_q   <= 1'b0;
      weight_q       <= weight_init;
      pot_cand_q     <= 1'b0;
      dep_cand_q     <= 1'b0;
      pot_delta_q    <= '0;
      dep_delta_q    <= '0;
    end else begin
      apply_q        <= 1'b0;
      weight_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StApply;
            apply_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StApply: begin
          state_q  <= StSettle;
          settle_q <= '0;
        end
        StSettle: begin
          if (settle_q == SettleLast) state_q <= StSample;
          else settle_q <= settle_q + 4'd1;
        end
        StSample: begin
          // Deltas use the latch values from before this step's spikes.
          pot_cand_q  <= is_spiking2 && pre_valid_q && !is_spiking1;
          dep_cand_q  <= is_spiking1 && post_valid_q && !is_spiking2;
          pot_delta_q <= step_q - pre_time_q;
          dep_delta_q <= step_q - post_time_q;
          if (is_spiking1) begin
            pre_time_q  <= step_q;
            pre_valid_q <= 1'b1;
          end
          if (is_spiking2) begin
            post_time_q  <= step_q;
            post_valid_q <= 1'b1;
          end
          state_q <= StUpdate;
        end
        StUpdate: begin
          weight_q       <= weight_next;
          weight_valid_q <= (weight_next != weight_q);
          step_q         <= step_q + Q'(1);
          pot_cand_q     <= 1'b0;
          dep_cand_q     <= 1'b0;
          if (run) begin
            state_q <= StApply;
            apply_q <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign apply          = apply_q;
  assign busy           = busy_q;
  assign step_count     = step_q;
  assign last_pre_time  = pre_time_q;
  assign last_post_time = post_time_q;
  assign pre_valid      = pre_valid_q;
  assign post_valid     = post_valid_q;
  assign weight         = weight_q;
  assign weight_valid   = weight_valid_q;

endmodule

// File: tb/tb_stdp_step_scheduler.sv
// Step-level bench: per-step spike vectors with expected results, checked via a scoreboard.
// A second instance with Q = 4 exercises timestep wrap.
module tb_stdp_step_scheduler;

  logic clk = 1'b0;
  logic rst, run, enable_stdp, is1, is2;
  logic signed [31:0] weight_init, w_min, w_max, m1, b1, m2, b2;
  logic [15:0] window;

  logic apply_a, busy_a, pv_a, qv_a, wv_a;
  logic [15:0] sc_a, lpre_a, lpost_a;
  logic signed [31:0] w_a;
  logic apply_b, busy_b, pv_b, qv_b, wv_b;
  logic [3:0] sc_b, lpre_b, lpost_b;
  logic signed [31:0] w_b;

  stdp_step_scheduler #(.N(32), .Q(16), .SETTLE_CYCLES(1)) dut (
    .clk (clk), .rst (rst), .run (run), .enable_stdp (enable_stdp),
    .is_spiking1 (is1), .is_spiking2 (is2), .weight_init (weight_init),
    .w_min (w_min), .w_max (w_max), .m1 (m1), .b1 (b1), .m2 (m2), .b2 (b2),
    .window (window), .apply (apply_a), .busy (busy_a), .step_count (sc_a),
    .last_pre_time (lpre_a), .last_post_time (lpost_a), .pre_valid (pv_a),
    .post_valid (qv_a), .weight (w_a), .weight_valid (wv_a)
  );

  stdp_step_scheduler #(.N(32), .Q(4), .SETTLE_CYCLES(1)) dut4 (
    .clk (clk), .rst (rst), .run (run), .enable_stdp (enable_stdp),
    .is_spiking1 (is1), .is_spiking2 (is2), .weight_init (weight_init),
    .w_min (w_min), .w_max (w_max), .m1 (m1), .b1 (b1), .m2 (m2), .b2 (b2),
    .window (window[3:0]), .apply (apply_b), .busy (busy_b), .step_count (sc_b),
    .last_pre_time (lpre_b), .last_post_time (lpost_b), .pre_valid (pv_b),
    .post_valid (qv_b), .weight (w_b), .weight_valid (wv_b)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic use4 = 1'b0;
  logic o_apply, o_busy, o_pv, o_qv, o_wv;
  logic [15:0] o_sc, o_lpre, o_lpost;
  logic [31:0] o_w;

  always_comb begin
    o_apply = apply_a; o_busy = busy_a; o_pv = pv_a; o_qv = qv_a; o_wv = wv_a;
    o_sc = sc_a; o_lpre = lpre_a; o_lpost = lpost_a; o_w = w_a;
    if (use4) begin
      o_apply = apply_b; o_busy = busy_b; o_pv = pv_b; o_qv = qv_b; o_wv = wv_b;
      o_sc = {12'd0, sc_b}; o_lpre = {12'd0, lpre_b}; o_lpost = {12'd0, lpost_b}; o_w = w_b;
    end
  end

  typedef struct {
    logic pre, post;
    logic [31:0] w;
    logic wv;
    logic [15:0] lpre, lpost;
    logic pv, qv;
  } vec_t;

  typedef struct {
    int k;
    logic [15:0] sc, lpre, lpost;
    logic [31:0] w;
    logic wv, pv, qv;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic pre, input logic post, input logic [31:0] w, input logic wv,
                     input logic [15:0] lpre, input logic [15:0] lpost,
                     input logic pv, input logic qv);
    vec_t v;
    v.pre = pre; v.post = post; v.w = w; v.wv = wv;
    v.lpre = lpre; v.lpost = lpost; v.pv = pv; v.qv = qv;
    vt.push_back(v);
  endtask

  task automatic idle(input int n, input logic [31:0] w, input logic [15:0] lpre,
                      input logic [15:0] lpost, input logic pv, input logic qv);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, w, 1'b0, lpre, lpost, pv, qv);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; is1 = 1'b0; is2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_weight", o_w, weight_init);
    chk("reset_apply_busy", {30'd0, o_apply, o_busy}, 32'd0);
    chk("reset_step", {16'd0, o_sc}, 32'd0);
    chk("reset_valids", {29'd0, o_pv, o_qv, o_wv}, 32'd0);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("k%0d_step", e.k), {16'd0, o_sc}, {16'd0, e.sc});
    chk($sformatf("k%0d_weight", e.k), o_w, e.w);
    chk($sformatf("k%0d_wvalid", e.k), {31'd0, o_wv}, {31'd0, e.wv});
    chk($sformatf("k%0d_pre_time", e.k), {16'd0, o_lpre}, {16'd0, e.lpre});
    chk($sformatf("k%0d_post_time", e.k), {16'd0, o_lpost}, {16'd0, e.lpost});
    chk($sformatf("k%0d_valids", e.k), {30'd0, o_pv, o_qv}, {30'd0, e.pv, e.qv});
  endtask

  task automatic wait_apply(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (o_apply) begin ok = 1'b1; break; end
    end
    if (!ok) chk("apply_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_scn(input int start, input int count, input logic is4);
    int prev;
    bit ok;
    exp_t e;
    use4 = is4;
    do_reset();
    run = 1'b1;
    prev = 0;
    for (int k = 0; k < count; k++) begin
      wait_apply(ok);
      if (k > 0) chk($sformatf("k%0d_period", k), cycle - prev, 32'd4);
      else chk("k0_start_step", {16'd0, o_sc}, 32'd0);
      prev = cycle;
      if (k > 0) pop_check();
      is1 = vt[start+k].pre;
      is2 = vt[start+k].post;
      e.k = k;
      e.sc = is4 ? 16'((k + 1) % 16) : 16'(k + 1);
      e.w = vt[start+k].w; e.wv = vt[start+k].wv;
      e.lpre = vt[start+k].lpre; e.lpost = vt[start+k].lpost;
      e.pv = vt[start+k].pv; e.qv = vt[start+k].qv;
      sb.push_back(e);
      if (k == count - 1) run = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!o_busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    pop_check();
    is1 = 1'b0; is2 = 1'b0;
  endtask

  task automatic cfg_default();
    enable_stdp = 1'b1;
    weight_init = 32'h0001_0000;
    w_min = 32'h0000_0000; w_max = 32'h0010_0000;
    m1 = 32'h0000_1000; b1 = 32'h0000_8000;
    m2 = 32'h0000_1000; b2 = 32'h0000_4000;
    window = 16'd20;
  endtask

  int s_a, s_b, s_c, s_d, s_e, s_f, s_g;
  bit ok_w;

  initial begin
    rst = 1'b1; run = 1'b0; is1 = 1'b0; is2 = 1'b0;
    cfg_default();

    // Per-step vectors: pre, post, weight, weight_valid, pre_time, post_time, pre_v, post_v.
    s_a = vt.size(); idle(4, 32'h10000, 0, 0, 0, 0);
    s_b = vt.size(); idle(2, 32'h10000, 0, 0, 0, 0);
    add(1, 0, 32'h10000, 0, 2, 0, 1, 0); idle(2, 32'h10000, 2, 0, 1, 0);
    add(0, 1, 32'h15000, 1, 2, 5, 1, 1);
    s_c = vt.size(); idle(2, 32'h10000, 0, 0, 0, 0);
    add(0, 1, 32'h10000, 0, 0, 2, 0, 1); idle(1, 32'h10000, 0, 2, 0, 1);
    add(1, 0, 32'h0E000, 1, 4, 2, 1, 1);
    s_d = vt.size(); idle(3, 32'h10000, 0, 0, 0, 0);
    add(1, 1, 32'h10000, 0, 3, 3, 1, 1); idle(2, 32'h10000, 3, 3, 1, 1);
    add(0, 1, 32'h12000, 1, 3, 6, 1, 1);
    s_e = vt.size(); add(1, 0, 32'h10000, 0, 0, 0, 1, 0);
    idle(19, 32'h10000, 0, 0, 1, 0); add(0, 1, 32'h10000, 0, 0, 20, 1, 1);
    s_f = vt.size(); idle(2, 32'h10000, 0, 0, 0, 0);
    add(1, 0, 32'h10000, 0, 2, 0, 1, 0); idle(2, 32'h10000, 2, 0, 1, 0);
    add(0, 1, 32'h10000, 0, 2, 5, 1, 1);
    s_g = vt.size(); idle(14, 32'h10000, 0, 0, 0, 0);
    add(1, 0, 32'h10000, 0, 14, 0, 1, 0); idle(2, 32'h10000, 14, 0, 1, 0);
    add(0, 1, 32'h15000, 1, 14, 1, 1, 1);

    run_scn(s_a, 4, 1'b0);
    run_scn(s_c, 5, 1'b0);
    cfg_default(); w_max = 32'h0001_2000;
    run_scn(s_d, 7, 1'b0);
    cfg_default(); b1 = 32'h0002_0000;
    run_scn(s_e, 21, 1'b0);
    cfg_default(); enable_stdp = 1'b0;
    run_scn(s_f, 6, 1'b0);
    cfg_default(); window = 16'd5;
    run_scn(s_g, 18, 1'b1);
    cfg_default();
    run_scn(s_b, 6, 1'b0);

    // Reset landing in SETTLE after a potentiated run: everything clears at once.
    run = 1'b1;
    wait_apply(ok_w);
    @(negedge clk);
    weight_init = 32'h0002_0000;
    rst = 1'b1;
    #1;
    chk("midrst_apply_busy", {30'd0, o_apply, o_busy}, 32'd0);
    chk("midrst_step", {16'd0, o_sc}, 32'd0);
    chk("midrst_valids", {29'd0, o_pv, o_qv, o_wv}, 32'd0);
    chk("midrst_weight", o_w, 32'h0002_0000);
    chk("midrst_times", {o_lpre, o_lpost}, 32'd0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_stays_idle", {30'd0, o_apply, o_busy}, 32'd0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
